// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned NxN shift-and-add multiplier.
// Adds one selected partial product per cycle; N+1 cycles per product.
module seq_shift_add_mult #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_h;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_p;
  logic [N-1:0]    w_pp;
  logic [N:0]      w_sum;
  logic            w_accept;
  logic            w_last;

  // Partial-product select: multiplicand or zero, steered by multiplier LSB
  assign w_pp   = r_q[0] ? r_a : '0;
  assign w_sum  = {1'b0, r_h} + {1'b0, w_pp};
  assign w_last = (r_cnt == CW'(N - 1));
  assign p      = r_p;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_h     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= a;
        r_q   <= b;
        r_h   <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        // {C,S,Q} shifted right by one: carry lands in the top of H
        r_h   <= w_sum[N:1];
        r_q   <= {w_sum[0], r_q[N-1:1]};
        r_cnt <= r_cnt + CW'(1);
        if (w_last) r_p <= {w_sum, r_q[N-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: directed N=4 cases and N=8 random run.
// Expected products come from plain multiplication.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        s4_start;
  logic [3:0]  s4_a;
  logic [3:0]  s4_b;
  logic [7:0]  s4_p;
  logic        s4_busy;
  logic        s4_done;
  logic        s8_start;
  logic [7:0]  s8_a;
  logic [7:0]  s8_b;
  logic [15:0] s8_p;
  logic        s8_busy;
  logic        s8_done;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.N(4)) u_m4 (
    .clk   (clk),
    .rst   (rst),
    .start (s4_start),
    .a     (s4_a),
    .b     (s4_b),
    .p     (s4_p),
    .busy  (s4_busy),
    .done  (s4_done)
  );

  seq_shift_add_mult #(.N(8)) u_m8 (
    .clk   (clk),
    .rst   (rst),
    .start (s8_start),
    .a     (s8_a),
    .b     (s8_b),
    .p     (s8_p),
    .busy  (s8_busy),
    .done  (s8_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input bit repulse);
    logic [7:0] e;
    e = {4'b0, a} * {4'b0, b};
    s4_a = a;
    s4_b = b;
    s4_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      chk("busy4", s4_busy, c <= 4);
      chk("done4", s4_done, c == 5);
      if (c == 5) chk("p4", s4_p, e);
      s4_start = repulse && (c == 2 || c == 3);
      if (s4_start) begin
        s4_a = 4'd1;
        s4_b = 4'd1;
      end else begin
        s4_a = 4'($urandom);
        s4_b = 4'($urandom);
      end
    end
    tick;
    chk("hold_p4", s4_p, e);
    chk("idle_done4", s4_done, 0);
    chk("idle_busy4", s4_busy, 0);
  endtask

  task automatic held4;
    s4_a = 4'd7;
    s4_b = 4'd6;
    s4_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      chk("b2b_done", s4_done, c == 5 || c == 10);
      chk("b2b_busy", s4_busy, !(c == 5 || c == 10));
      if (c == 5) begin
        chk("b2b_p42", s4_p, 42);
        s4_a = 4'd12;
        s4_b = 4'd10;
      end
      if (c > 5 && c < 10) chk("b2b_hold", s4_p, 42);
      if (c == 10) begin
        chk("b2b_p120", s4_p, 120);
        s4_start = 1'b0;
      end
    end
    tick;
  endtask

  task automatic abort4;
    s4_a = 4'd15;
    s4_b = 4'd15;
    s4_start = 1'b1;
    tick;
    s4_start = 1'b0;
    chk("abort_busy1", s4_busy, 1);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_p", s4_p, 0);
    chk("abort_busy", s4_busy, 0);
    chk("abort_done", s4_done, 0);
    tick;
    chk("abort_idle", s4_busy, 0);
    op4(4'd5, 4'd3, 1'b0);
  endtask

  task automatic rand8(input int nops);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] e;
    int          gap;
    a = 8'd255;
    b = 8'd255;
    e = {8'b0, a} * {8'b0, b};
    s8_a = a;
    s8_b = b;
    s8_start = 1'b1;
    for (int k = 0; k < nops; k++) begin
      for (int c = 1; c <= 9; c++) begin
        tick;
        chk("busy8", s8_busy, c <= 8);
        chk("done8", s8_done, c == 9);
        if (c < 9) begin
          s8_start = 1'($urandom_range(0, 1));
          s8_a = 8'($urandom);
          s8_b = 8'($urandom);
        end else begin
          chk("p8", s8_p, e);
          a = 8'($urandom);
          b = 8'($urandom);
          if ($urandom_range(0, 1) == 0) begin
            s8_start = 1'b0;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
              tick;
              chk("gap_busy8", s8_busy, 0);
              chk("gap_done8", s8_done, 0);
              chk("gap_p8", s8_p, e);
            end
          end
          s8_a = a;
          s8_b = b;
          s8_start = 1'b1;
          e = {8'b0, a} * {8'b0, b};
        end
      end
    end
    s8_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s4_start = 1'b0;
    s4_a = '0;
    s4_b = '0;
    s8_start = 1'b0;
    s8_a = '0;
    s8_b = '0;
    tick;
    tick;
    chk("rst_p4", s4_p, 0);
    chk("rst_busy4", s4_busy, 0);
    chk("rst_done4", s4_done, 0);
    chk("rst_p8", s8_p, 0);
    chk("rst_busy8", s8_busy, 0);
    rst = 1'b0;
    tick;
    op4(4'd13, 4'd11, 1'b0);
    op4(4'd15, 4'd15, 1'b0);
    op4(4'd0, 4'd9, 1'b0);
    op4(4'd9, 4'd0, 1'b0);
    op4(4'd13, 4'd11, 1'b1);
    held4;
    abort4;
    rand8(1200);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
